// File: rtl/lcd_write_sequencer.sv
// -----------------------------------------------------------------------------
// lcd_write_sequencer
//
// Write-side driver for an HD44780-style character LCD. After reset it waits
// out the panel power-on time, then plays a fixed six-byte init sequence
// (function set x3, display on, clear, entry mode). Once init is complete it
// accepts one command or data byte at a time from the core over a valid/ready
// handshake. Every byte is strobed onto the bus with programmable
// setup / enable / hold times and is followed by the execution wait the
// controller needs before it will take the next byte.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   in_valid   core presents a byte
//   in_rs      0 = command, 1 = character data
//   in_data    byte to write
//   in_ready   sequencer accepts a byte this cycle (high only when idle)
//   init_done  init sequence complete; stays high until reset
//   lcd_en     LCD enable strobe
//   lcd_rs     LCD register select
//   lcd_rw     LCD read/write, always 0 (write only)
//   lcd_data   LCD data bus
// -----------------------------------------------------------------------------
module lcd_write_sequencer #(
    parameter int SETUP_CYC      = 2,
    parameter int EN_CYC         = 12,
    parameter int HOLD_CYC       = 2,
    parameter int CMD_WAIT_CYC   = 2000,
    parameter int CLEAR_WAIT_CYC = 82000,
    parameter int POWERON_CYC    = 750000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic       in_rs,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       init_done,
    output logic       lcd_en,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic [7:0] lcd_data
);

    // One shared counter serves every timed state, so it is sized for the
    // longest interval of all of them.
    localparam int MAX_A   = (SETUP_CYC > EN_CYC) ? SETUP_CYC : EN_CYC;
    localparam int MAX_B   = (HOLD_CYC > CMD_WAIT_CYC) ? HOLD_CYC : CMD_WAIT_CYC;
    localparam int MAX_C   = (CLEAR_WAIT_CYC > POWERON_CYC) ? CLEAR_WAIT_CYC : POWERON_CYC;
    localparam int MAX_AB  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int MAX_CYC = (MAX_AB > MAX_C) ? MAX_AB : MAX_C;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] SETUP_LAST   = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] EN_LAST      = CNT_W'(EN_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] CMD_LAST     = CNT_W'(CMD_WAIT_CYC - 1);
    localparam logic [CNT_W-1:0] CLEAR_LAST   = CNT_W'(CLEAR_WAIT_CYC - 1);
    localparam logic [CNT_W-1:0] POWERON_LAST = CNT_W'(POWERON_CYC - 1);

    localparam logic [2:0] INIT_LAST_IDX = 3'd5;

    typedef enum logic [2:0] {
        ST_POWERON,
        ST_INIT,
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD,
        ST_WAIT
    } state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [2:0]       idx_reg, idx_next;
    logic [7:0]       data_reg, data_next;
    logic             rs_reg, rs_next;
    logic             en_reg, en_next;
    logic             init_done_reg, init_done_next;

    logic [CNT_W-1:0] cnt_limit;
    logic             cnt_last;
    logic             long_wait;

    // Power-on init sequence: function set (8-bit, 2 lines) three times,
    // display on / cursor off, clear, entry mode increment.
    function automatic logic [7:0] init_rom(input logic [2:0] idx);
        case (idx)
            3'd0:    init_rom = 8'h38;
            3'd1:    init_rom = 8'h38;
            3'd2:    init_rom = 8'h38;
            3'd3:    init_rom = 8'h0C;
            3'd4:    init_rom = 8'h01;
            3'd5:    init_rom = 8'h06;
            default: init_rom = 8'h00;
        endcase
    endfunction

    // Clear (0x01) and return-home (0x02/0x03) are the slow commands. The
    // decode is a plain top-six-bits-zero test, so 0x00 also gets the long
    // wait; that costs time on a no-op but is never too short.
    assign long_wait = !rs_reg && (data_reg[7:2] == 6'd0);

    always_comb begin
        cnt_limit = '0;
        case (state_reg)
            ST_POWERON: cnt_limit = POWERON_LAST;
            ST_SETUP:   cnt_limit = SETUP_LAST;
            ST_PULSE:   cnt_limit = EN_LAST;
            ST_HOLD:    cnt_limit = HOLD_LAST;
            ST_WAIT:    cnt_limit = long_wait ? CLEAR_LAST : CMD_LAST;
            default:    cnt_limit = '0;
        endcase
    end

    assign cnt_last = (cnt_reg == cnt_limit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_POWERON;
            cnt_reg       <= '0;
            idx_reg       <= '0;
            data_reg      <= 8'h00;
            rs_reg        <= 1'b0;
            en_reg        <= 1'b0;
            init_done_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            idx_reg       <= idx_next;
            data_reg      <= data_next;
            rs_reg        <= rs_next;
            en_reg        <= en_next;
            init_done_reg <= init_done_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        idx_next       = idx_reg;
        data_next      = data_reg;
        rs_next        = rs_reg;
        en_next        = en_reg;
        init_done_next = init_done_reg;

        case (state_reg)
            ST_POWERON: begin
                if (cnt_last) begin
                    cnt_next   = '0;
                    state_next = ST_INIT;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end

            ST_INIT: begin
                data_next  = init_rom(idx_reg);
                rs_next    = 1'b0;
                cnt_next   = '0;
                state_next = ST_SETUP;
            end

            ST_IDLE: begin
                en_next = 1'b0;
                if (in_valid) begin
                    data_next  = in_data;
                    rs_next    = in_rs;
                    cnt_next   = '0;
                    state_next = ST_SETUP;
                end
            end

            ST_SETUP: begin
                if (cnt_last) begin
                    cnt_next   = '0;
                    en_next    = 1'b1;
                    state_next = ST_PULSE;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end

            ST_PULSE: begin
                if (cnt_last) begin
                    cnt_next   = '0;
                    en_next    = 1'b0;
                    state_next = ST_HOLD;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end

            ST_HOLD: begin
                if (cnt_last) begin
                    cnt_next   = '0;
                    state_next = ST_WAIT;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end

            ST_WAIT: begin
                if (cnt_last) begin
                    cnt_next = '0;
                    if (init_done_reg) begin
                        state_next = ST_IDLE;
                    end else if (idx_reg == INIT_LAST_IDX) begin
                        init_done_next = 1'b1;
                        state_next     = ST_IDLE;
                    end else begin
                        idx_next   = idx_reg + 3'd1;
                        state_next = ST_INIT;
                    end
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end

            default: begin
                state_next = ST_POWERON;
                cnt_next   = '0;
                en_next    = 1'b0;
            end
        endcase
    end

    // lcd_en comes straight from a flop so the strobe is glitch-free and is
    // cleared by the asynchronous reset the moment rst_n falls.
    assign in_ready  = (state_reg == ST_IDLE);
    assign init_done = init_done_reg;
    assign lcd_en    = en_reg;
    assign lcd_rs    = rs_reg;
    assign lcd_rw    = 1'b0;
    assign lcd_data  = data_reg;

endmodule

// File: tb/tb_lcd_write_sequencer.sv
module tb_lcd_write_sequencer;

    localparam int S  = 2;
    localparam int E  = 3;
    localparam int H  = 1;
    localparam int CW = 5;
    localparam int LW = 9;
    localparam int P  = 20;
    localparam int ACCEPT_LIMIT = 500;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_rs = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready;
    logic       init_done;
    logic       lcd_en;
    logic       lcd_rs;
    logic       lcd_rw;
    logic [7:0] lcd_data;

    lcd_write_sequencer #(
        .SETUP_CYC      (S),
        .EN_CYC         (E),
        .HOLD_CYC       (H),
        .CMD_WAIT_CYC   (CW),
        .CLEAR_WAIT_CYC (LW),
        .POWERON_CYC    (P)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_rs     (in_rs),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .init_done (init_done),
        .lcd_en    (lcd_en),
        .lcd_rs    (lcd_rs),
        .lcd_rw    (lcd_rw),
        .lcd_data  (lcd_data)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    logic [7:0] rom_tab [6] = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};

    // Bytes the core has handed over, in order; the bus must replay them.
    logic [8:0] sent_q [$];

    // ------------------------------------------------------------------
    // Reference model: a timeline. A byte loaded at edge N shows EN over
    // edges [N+S, N+S+E) and is finished at N+S+E+H+wait; the next init
    // byte loads one edge later, or the sequencer goes idle.
    // ------------------------------------------------------------------
    int         m_e = 0;
    int         m_load = 0;
    int         m_done_e = 0;
    int         m_next_init = P + 1;
    int         m_k = 0;
    bit         m_have = 0;
    bit         m_idle = 0;
    bit         m_was_idle = 0;
    bit         m_init_done = 0;
    bit         m_en = 0;
    bit         m_rs = 0;
    logic [7:0] m_data = 8'h00;

    function automatic int wait_len(input bit rs, input logic [7:0] d);
        return (!rs && d[7:2] == 6'd0) ? LW : CW;
    endfunction

    task automatic m_load_byte(input bit rs, input logic [7:0] d);
        m_have   = 1;
        m_load   = m_e;
        m_rs     = rs;
        m_data   = d;
        m_done_e = m_e + S + E + H + wait_len(rs, d);
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_e = 0; m_have = 0; m_next_init = P + 1; m_k = 0;
            m_idle = 0; m_init_done = 0; m_en = 0; m_rs = 0; m_data = 8'h00;
        end else begin
            m_e++;
            m_was_idle = m_idle;
            if (m_have && m_e == m_done_e) begin
                m_have = 0;
                if (m_k < 6) m_next_init = m_e + 1;
                else begin
                    m_init_done = 1;
                    m_idle = 1;
                end
            end
            if (m_was_idle && in_valid) begin
                m_load_byte(in_rs, in_data);
                m_idle = 0;
            end else if (!m_init_done && !m_have && m_k < 6 && m_e == m_next_init) begin
                m_load_byte(1'b0, rom_tab[m_k]);
                m_k++;
            end
            m_en = m_have && (m_e >= m_load + S) && (m_e < m_load + S + E);
        end
    end

    // ------------------------------------------------------------------
    // Per-cycle output check and bus scoreboard, sampled on falling edges.
    // ------------------------------------------------------------------
    bit         mon_prev_en = 0;
    int         mon_w = 0;
    int         mon_k = 0;
    int         mon_total = 0;
    logic [8:0] mon_cap = '0;
    logic [8:0] mon_exp;

    always @(negedge clk) begin
        if (!rst_n) begin
            mon_prev_en = 0;
            mon_w = 0;
            mon_k = 0;
        end else begin
            check_val("outputs", {18'd0, lcd_rw, lcd_en, in_ready, init_done, lcd_rs, lcd_data},
                      {18'd0, 1'b0, m_en, m_idle, m_init_done, m_rs, m_data});
            if (lcd_en) begin
                if (!mon_prev_en) begin
                    mon_cap = {lcd_rs, lcd_data};
                    mon_w = 0;
                end else begin
                    check_val("stable_during_en", {23'd0, lcd_rs, lcd_data}, {23'd0, mon_cap});
                end
                mon_w++;
            end else if (mon_prev_en) begin
                mon_total++;
                $display("xfer %0d: rs=%0d data=%02h en_width=%0d", mon_total, mon_cap[8], mon_cap[7:0], mon_w);
                check_val("en_width", mon_w, E);
                if (mon_k < 6) begin
                    check_val("init_byte", {23'd0, mon_cap}, {23'd0, 1'b0, rom_tab[mon_k]});
                end else begin
                    check_val("sb_nonempty", (sent_q.size() > 0), 1);
                    if (sent_q.size() > 0) begin
                        mon_exp = sent_q.pop_front();
                        check_val("bus_byte", {23'd0, mon_cap}, {23'd0, mon_exp});
                    end
                end
                mon_k++;
            end
            mon_prev_en = lcd_en;
        end
    end

    // Called just after a falling edge with in_valid already raised; holds
    // the byte until the handshake completes.
    task automatic wait_accept();
        int t;
        t = 0;
        while (!in_ready && t < ACCEPT_LIMIT) begin
            @(negedge clk);
            t++;
        end
        check_val("accept_in_time", (t < ACCEPT_LIMIT), 1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send(input bit rs, input logic [7:0] d, input int gap);
        repeat (gap) @(negedge clk);
        in_valid = 1'b1;
        in_rs    = rs;
        in_data  = d;
        sent_q.push_back({rs, d});
        wait_accept();
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (!in_ready && t < ACCEPT_LIMIT) begin
            @(negedge clk);
            t++;
        end
        check_val("idle_in_time", (t < ACCEPT_LIMIT), 1);
    endtask

    initial begin
        int t;
        bit rs;
        logic [7:0] d;

        // Byte held from reset: must land exactly once, right after init.
        in_valid = 1'b1;
        in_rs    = 1'b1;
        in_data  = 8'h55;
        sent_q.push_back({1'b1, 8'h55});
        #1;
        check_val("reset_state", {21'd0, in_ready, init_done, lcd_en, lcd_rs, lcd_rw, lcd_data}, 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        wait_accept();

        send(1'b1, 8'h41, 0);
        send(1'b0, 8'h01, 0);
        send(1'b0, 8'h80, 0);

        // Abort a transfer mid-pulse.
        send(1'b1, 8'h48, 0);
        t = 0;
        while (!lcd_en && t < 50) begin
            @(negedge clk);
            t++;
        end
        check_val("reach_pulse", lcd_en, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check_val("abort_en", lcd_en, 1'b0);
        check_val("abort_ready", in_ready, 1'b0);
        check_val("abort_init_done", init_done, 1'b0);
        void'(sent_q.pop_back());
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);

        // Random stream; init runs again first and send() waits it out.
        for (int i = 0; i < 50; i++) begin
            rs = 1'($urandom_range(0, 1));
            d  = 8'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                rs = 1'b0;
                d  = 8'($urandom_range(0, 3));
            end
            send(rs, d, $urandom_range(0, 4));
        end
        wait_idle();
        repeat (2) @(negedge clk);
        check_val("drain", sent_q.size(), 0);
        check_val("xfer_count", mon_total, 66);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

endmodule
